// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared state encoding and default tick values for btn_event_decoder
//
// Purpose : state type and parameter defaults used by the button event decoder.
// Contents: state_t (3-bit, IDLE=0), DEF_* tick defaults, is_held() helper.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

  localparam int DEF_CNT_WIDTH    = 8;
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_DBL_TICKS    = 30;
  localparam int DEF_REPEAT_TICKS = 10;

  // States in which the button is physically down.
  function automatic logic is_held(input state_t s);
    return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG);
  endfunction

endpackage

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies debounced button activity into single-cycle events
//
// Purpose : turns the debounced button level into SHORT/LONG/DOUBLE/REPEAT pulses,
//           all timing counted in CE ticks.
// Config  : define BTN_AUTOREPEAT_EN to enable auto-repeat while long-held;
//           otherwise o_repeat is tied to 0.
// Ports   : i_clk          system clock
//           i_rst          synchronous reset, active high
//           i_ce           timing tick (enables the tick counter)
//           i_btn_in       debounced button level, synchronous to i_clk
//           o_short_press  1-cycle pulse, single click confirmed
//           o_long_press   1-cycle pulse, hold reached LONG_TICKS
//           o_double_click 1-cycle pulse, second click released
//           o_repeat       1-cycle pulse, auto-repeat tick
//           o_btn_held     level, button down (PRESS1/PRESS2/LONG)
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DBL_TICKS    = DEF_DBL_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ce,
  input  logic i_btn_in,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_double_click,
  output logic o_repeat,
  output logic o_btn_held
);

`ifndef SYNTHESIS
  if (CNT_WIDTH < 1 || CNT_WIDTH > 31 ||
      LONG_TICKS < 2 || LONG_TICKS >= (1 << CNT_WIDTH) ||
      DBL_TICKS < 1 || DBL_TICKS >= (1 << CNT_WIDTH) ||
      REPEAT_TICKS < 1 || REPEAT_TICKS >= (1 << CNT_WIDTH)) begin : g_param_check
    $error("btn_event_decoder: illegal CNT_WIDTH / *_TICKS parameter combination");
  end
`endif

  // Thresholds compare against cnt before it increments, hence TICKS-1.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DBL_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_btn_q;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_cnt_clr;
  logic                 w_short;
  logic                 w_long;
  logic                 w_dbl;

  // r_btn_q is 0 out of reset, so a button already down at release reads as a rise.
  assign w_rise = i_btn_in & ~r_btn_q;
  assign w_fall = ~i_btn_in & r_btn_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);
  logic w_rep;
  // A fall in the same cycle leaves LONG and wins over the repeat.
  assign w_rep     = (r_state == ST_LONG) && !w_fall && i_ce && (r_cnt == REP_LAST);
  assign w_cnt_clr = (w_next_state != r_state) || w_rep;
`else
  assign w_cnt_clr = (w_next_state != r_state);
`endif

  always_comb begin
    w_next_state = r_state;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_dbl        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) w_next_state = ST_PRESS1;
      end
      ST_PRESS1: begin
        // Releasing on the threshold tick still counts as a click.
        if (w_fall) begin
          w_next_state = ST_WAIT2;
        end else if (i_ce && r_cnt == LONG_LAST) begin
          w_next_state = ST_LONG;
          w_long       = 1'b1;
        end
      end
      ST_WAIT2: begin
        // A second press on the timeout tick still makes a double click.
        if (w_rise) begin
          w_next_state = ST_PRESS2;
        end else if (i_ce && r_cnt == DBL_LAST) begin
          w_next_state = ST_IDLE;
          w_short      = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (w_fall) begin
          w_next_state = ST_IDLE;
          w_dbl        = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_fall) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_cnt_clr) begin
      w_cnt_next = '0;
    end else if (i_ce && r_cnt != CNT_MAX) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_btn_q        <= 1'b0;
      o_short_press  <= 1'b0;
      o_long_press   <= 1'b0;
      o_double_click <= 1'b0;
      o_btn_held     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_cnt_next;
      r_btn_q        <= i_btn_in;
      o_short_press  <= w_short;
      o_long_press   <= w_long;
      o_double_click <= w_dbl;
      o_btn_held     <= is_held(w_next_state);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_repeat <= 1'b0;
    end else begin
      o_repeat <= w_rep;
    end
  end
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - scoreboard bench for btn_event_decoder
module tb_btn_event_decoder;

  localparam int LONG_T = 8;
  localparam int DBL_T  = 4;
  localparam int REP_T  = 2;

  localparam logic [3:0] K_SHORT = 4'b1000;
  localparam logic [3:0] K_LONG  = 4'b0100;
  localparam logic [3:0] K_DBL   = 4'b0010;
  localparam logic [3:0] K_REP   = 4'b0001;

  typedef struct {
    int         idx;
    logic [3:0] kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic btn;
  logic o_short;
  logic o_long;
  logic o_dbl;
  logic o_rep;
  logic o_held;

  bit   q_btn[$];
  bit   q_ce[$];
  bit   q_rst[$];
  exp_t sb_q[$];
  bit   held_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_event_decoder #(
    .CNT_WIDTH   (8),
    .LONG_TICKS  (LONG_T),
    .DBL_TICKS   (DBL_T),
    .REPEAT_TICKS(REP_T)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ce          (ce),
    .i_btn_in      (btn),
    .o_short_press (o_short),
    .o_long_press  (o_long),
    .o_double_click(o_dbl),
    .o_repeat      (o_rep),
    .o_btn_held    (o_held)
  );

  // mode 0: CE every cycle, 1: CE 1-in-4, 2: random CE
  task automatic add(input int len, input bit b, input int mode, input bit r);
    for (int i = 0; i < len; i++) begin
      q_btn.push_back(b);
      q_rst.push_back(r);
      case (mode)
        0:       q_ce.push_back(1'b1);
        1:       q_ce.push_back(q_ce.size() % 4 == 0);
        default: q_ce.push_back(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  // Reference model: the button's level history is scanned for press/release
  // edges, and each event lands on the Nth CE tick after the edge that starts
  // its timing window, provided no cancelling edge or reset comes first.
  function automatic bit prev_lvl(input int k);
    if (k == 0) return 1'b0;
    if (q_rst[k-1]) return 1'b0;
    return q_btn[k-1];
  endfunction

  function automatic int next_edge(input int from, input bit want_rise);
    for (int k = from + 1; k < q_btn.size(); k++) begin
      if (!q_rst[k] && q_btn[k] == want_rise && prev_lvl(k) != want_rise) return k;
    end
    return q_btn.size();
  endfunction

  function automatic int next_rst(input int from);
    for (int k = from + 1; k < q_rst.size(); k++) begin
      if (q_rst[k]) return k;
    end
    return q_rst.size();
  endfunction

  function automatic int nth_tick(input int from, input int n);
    int c = 0;
    for (int k = from + 1; k < q_ce.size(); k++) begin
      if (q_ce[k]) begin
        c++;
        if (c == n) return k;
      end
    end
    return q_ce.size();
  endfunction

  task automatic push_ev(input int idx, input logic [3:0] kind);
    exp_t e;
    e.idx  = idx;
    e.kind = kind;
    sb_q.push_back(e);
  endtask

  task automatic build_expected();
    int n;
    int k;
    int r;
    int f;
    int x;
    int t;
    int s;
    int q;
    n = q_btn.size();
    k = -1;
    for (int i = 0; i < n; i++) held_q.push_back(q_btn[i] && !q_rst[i]);
    while (k < n) begin
      r = next_edge(k, 1'b1);
      if (r >= n) break;
      f = next_edge(r, 1'b0);
      x = next_rst(r);
      t = nth_tick(r, LONG_T);
      if (t < f && t < x) begin
        push_ev(t, K_LONG);
`ifdef BTN_AUTOREPEAT_EN
        q = t;
        while (1'b1) begin
          q = nth_tick(q, REP_T);
          if (q < f && q < x) push_ev(q, K_REP);
          else break;
        end
`else
        q = 0;
`endif
        k = (x < f) ? x : f;
        continue;
      end
      if (x < f) begin k = x; continue; end
      if (f >= n) break;
      r = next_edge(f, 1'b1);
      x = next_rst(f);
      s = nth_tick(f, DBL_T);
      if (s < r && s < x) begin
        push_ev(s, K_SHORT);
        k = s;
        continue;
      end
      if (x < r) begin k = x; continue; end
      if (r >= n) break;
      f = next_edge(r, 1'b0);
      x = next_rst(r);
      if (x < f) begin k = x; continue; end
      if (f >= n) break;
      push_ev(f, K_DBL);
      k = f;
    end
  endtask

  initial begin
    int m;
    // reset and idle
    add(3, 0, 0, 1);
    add(3, 0, 0, 0);
    // T1 short, T2 double, T3 long with repeat
    add(3, 1, 0, 0); add(10, 0, 0, 0);
    add(3, 1, 0, 0); add(2, 0, 0, 0); add(3, 1, 0, 0); add(10, 0, 0, 0);
    add(20, 1, 0, 0); add(10, 0, 0, 0);
    // T4: fall on the long threshold tick, one past it, rise on WAIT2 timeout, one after
    add(LONG_T, 1, 0, 0); add(10, 0, 0, 0);
    add(LONG_T + 1, 1, 0, 0); add(10, 0, 0, 0);
    add(3, 1, 0, 0); add(DBL_T, 0, 0, 0); add(3, 1, 0, 0); add(10, 0, 0, 0);
    add(3, 1, 0, 0); add(DBL_T + 1, 0, 0, 0); add(3, 1, 0, 0); add(10, 0, 0, 0);
    // T5: CE 1-in-4
    add(12, 1, 1, 0); add(40, 0, 1, 0);
    add(8, 1, 1, 0); add(6, 0, 1, 0); add(8, 1, 1, 0); add(40, 0, 1, 0);
    add(80, 1, 1, 0); add(40, 0, 1, 0);
    // T6: reset mid-PRESS1, mid-LONG, and release of reset with button down
    add(3, 1, 0, 0); add(2, 0, 0, 1); add(10, 0, 0, 0);
    add(15, 1, 0, 0); add(2, 0, 0, 1); add(10, 0, 0, 0);
    add(3, 1, 0, 0); add(2, 1, 0, 1); add(3, 1, 0, 0); add(10, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 80; i++) begin
      m = $urandom_range(0, 2);
      add($urandom_range(1, 12), 1, m, 0);
      add($urandom_range(1, 8), 0, m, 0);
      if ($urandom_range(0, 9) == 0) add($urandom_range(1, 2), 1'($urandom_range(0, 1)), m, 1);
    end
    add(20, 0, 0, 0);

    build_expected();

    btn = q_btn[0];
    ce  = q_ce[0];
    rst = q_rst[0];

    fork
      begin : driver
        for (int k = 1; k < q_btn.size(); k++) begin
          @(posedge clk);
          #1;
          btn = q_btn[k];
          ce  = q_ce[k];
          rst = q_rst[k];
        end
      end
      begin : monitor
        logic [3:0] act;
        exp_t       e;
        bit         eh;
        for (int k = 0; k < q_btn.size(); k++) begin
          @(negedge clk);
          act = {o_short, o_long, o_dbl, o_rep};
          while (sb_q.size() > 0 && sb_q[0].idx < k) begin
            e = sb_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_pulse cycle=%0d actual=none required=%b", e.idx, e.kind);
          end
          total++;
          if (sb_q.size() > 0 && sb_q[0].idx == k) begin
            e = sb_q.pop_front();
            if (act !== e.kind) begin
              bad++;
              $display("FAIL pulse cycle=%0d actual=%b required=%b", k, act, e.kind);
            end
          end else if (act !== 4'b0000) begin
            bad++;
            $display("FAIL spurious_pulse cycle=%0d actual=%b required=0000", k, act);
          end
          eh = held_q.pop_front();
          total++;
          if (o_held !== eh) begin
            bad++;
            $display("FAIL btn_held cycle=%0d actual=%b required=%b", k, o_held, eh);
          end
        end
      end
    join

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_pulse cycle=%0d actual=none required=%b", e.idx, e.kind);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
